gen_clk_div: RTL and testbench



---
 rtl/gen_clk_div_if.sv | 18 +
 rtl/gen_clk_div.sv | 30 +++
 tb/tb_gen_clk_div.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/gen_clk_div_if.sv
// rtl/gen_clk_div_if.sv - enable and divided lane clock bundle for gen_clk_div
interface gen_clk_div_if;
    logic enb;
    logic clk_2f;
    logic clk_f;

    modport master (
        output enb,
        input  clk_2f,
        input  clk_f
    );

    modport slave (
        input  enb,
        output clk_2f,
        output clk_f
    );
endinterface

// File: rtl/gen_clk_div.sv
// rtl/gen_clk_div.sv - phase-locked /4 and /8 lane clocks from the 8f master clock
module gen_clk_div (
    input  logic          clk_8f,
    input  logic          rst,
    gen_clk_div_if.slave  div
);

    logic [2:0] cnt_d;
    logic [2:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (div.enb) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk_8f or negedge rst) begin
        if (!rst) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Outputs are taken straight from counter flops so both clocks stay glitch-free and edge-aligned.
    assign div.clk_2f = cnt_q[1];
    assign div.clk_f  = cnt_q[2];

endmodule

// File: tb/tb_gen_clk_div.sv
// tb/tb_gen_clk_div.sv - directed self-checking bench for gen_clk_div
module tb_gen_clk_div;

    logic clk_8f = 1'b0;
    logic rst    = 1'b0;

    gen_clk_div_if bus ();

    gen_clk_div dut (
        .clk_8f (clk_8f),
        .rst    (rst),
        .div    (bus)
    );

    always #5 clk_8f = ~clk_8f;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic rst;
        logic enb;
        logic e2f;
        logic ef;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got {clk_2f,clk_f}=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic e);
        @(negedge clk_8f);
        rst     = r;
        bus.enb = e;
        @(posedge clk_8f);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_8f);
        rst     = 1'b0;
        bus.enb = 1'b0;
        @(negedge clk_8f);
        rst     = 1'b1;
    endtask

    logic [7:0] seq_2f;
    logic [7:0] seq_f;
    logic       p2f, pf;
    int         rise_2f, rise_f;

    initial begin
        bus.enb = 1'b0;
        seq_2f  = 8'b0110_0110;
        seq_f   = 8'b0001_1110;

        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 1'b0};

        // Reset held with enb toggling
        for (int i = 0; i < 20; i++) begin
            step(1'b0, i[0]);
            check("reset_hold", {bus.clk_2f, bus.clk_f}, 2'b00);
        end

        // Table: count, freeze, wrap, synchronous-looking reset, restart
        for (int i = 0; i < 16; i++) begin
            step(vecs[i].rst, vecs[i].enb);
            check($sformatf("vec%0d", i), {bus.clk_2f, bus.clk_f}, {vecs[i].e2f, vecs[i].ef});
        end

        // Enabled run from reset: 50 edges
        do_reset();
        for (int k = 1; k <= 50; k++) begin
            step(1'b1, 1'b1);
            check($sformatf("run_edge%0d", k), {bus.clk_2f, bus.clk_f},
                  {seq_2f[7 - ((k - 1) % 8)], seq_f[7 - ((k - 1) % 8)]});
        end

        // Disabled after reset, counter must not move
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0);
            check("disabled", {bus.clk_2f, bus.clk_f}, 2'b00);
        end
        step(1'b1, 1'b1);
        check("disabled_e1", {bus.clk_2f, bus.clk_f}, 2'b00);
        step(1'b1, 1'b1);
        check("disabled_e2", {bus.clk_2f, bus.clk_f}, 2'b10);

        // Freeze at cnt=5, resume to cnt=6
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
        check("freeze_cnt5", {bus.clk_2f, bus.clk_f}, 2'b01);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0);
            check("freeze_hold", {bus.clk_2f, bus.clk_f}, 2'b01);
        end
        step(1'b1, 1'b1);
        check("resume_cnt6", {bus.clk_2f, bus.clk_f}, 2'b11);

        // Async reset in the middle of a clk_f high phase
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
        check("pre_async", {bus.clk_2f, bus.clk_f}, 2'b11);
        @(negedge clk_8f);
        #2;
        rst = 1'b0;
        #1;
        check("async_clear", {bus.clk_2f, bus.clk_f}, 2'b00);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            check("async_held", {bus.clk_2f, bus.clk_f}, 2'b00);
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b1);
            check($sformatf("post_async%0d", k + 1), {bus.clk_2f, bus.clk_f},
                  {seq_2f[7 - k], seq_f[7 - k]});
        end

        // Phase relation and rising-edge counts over 64 enabled cycles
        do_reset();
        p2f     = 1'b0;
        pf      = 1'b0;
        rise_2f = 0;
        rise_f  = 0;
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 1'b1);
            if (bus.clk_f !== pf) begin
                check("phase_lock", {bus.clk_2f !== p2f, 1'b1}, 2'b11);
                if (bus.clk_f === 1'b1)
                    check("f_rise_on_2f_fall", {bus.clk_2f, bus.clk_f}, 2'b01);
            end
            if (bus.clk_2f === 1'b1 && p2f === 1'b0) rise_2f++;
            if (bus.clk_f === 1'b1 && pf === 1'b0) rise_f++;
            p2f = bus.clk_2f;
            pf  = bus.clk_f;
        end
        tests++;
        if (rise_2f != 16) begin
            fails++;
            $display("FAIL rise_count_2f: got %0d expected 16", rise_2f);
        end
        tests++;
        if (rise_f != 8) begin
            fails++;
            $display("FAIL rise_count_f: got %0d expected 8", rise_f);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
